// File: rtl/sc_pkg.sv
// Shared stochastic-computing fixed-point constants and helpers,
// used by both the bit-flip insertion stage and the window decoder.
package sc_pkg;

  localparam int SC_FBW = 4;
  localparam int ONE    = 1 << (SC_FBW - 1);
  localparam int HALF   = 1 << (SC_FBW - 2);

  function automatic int unsigned sat(input int unsigned x, input int unsigned bw);
    return (x > bw - 1) ? bw - 1 : x;
  endfunction

  // Ones count of a 2^l window -> probability with fbw-1 fractional bits.
  function automatic int unsigned scale(input int unsigned total, input int unsigned l,
                                        input int unsigned fbw);
    if (l >= fbw - 1)
      return total >> (l - (fbw - 1));
    else
      return total << ((fbw - 1) - l);
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Window bit/ones counter: latches the window exponent at window start
// and flags the last bit of each 2^L-bit window.
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iEn,
  input  logic [BITWIDTH-1:0] iWINLOG2,
  input  logic                iBit,
  output logic                oLast,
  output logic [BITWIDTH-1:0] oTotal,
  output logic [BITWIDTH-1:0] oEffL
);

  logic [BITWIDTH-1:0] bitCnt;
  logic [BITWIDTH-1:0] onesCnt;
  logic [BITWIDTH-1:0] winLog;
  logic [BITWIDTH-1:0] satL;
  logic [BITWIDTH-1:0] lastIdx;

  assign satL    = BITWIDTH'(sat(32'(iWINLOG2), BITWIDTH));
  // A new exponent only takes effect on the first bit of a window.
  assign oEffL   = (bitCnt == '0) ? satL : winLog;
  assign lastIdx = (BITWIDTH'(1) << oEffL) - BITWIDTH'(1);
  assign oLast   = iEn && (bitCnt == lastIdx);
  assign oTotal  = onesCnt + BITWIDTH'(iBit);

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      bitCnt  <= '0;
      onesCnt <= '0;
      winLog  <= satL;
    end else if (iEn) begin
      if (bitCnt == '0)
        winLog <= satL;
      if (oLast) begin
        bitCnt  <= '0;
        onesCnt <= '0;
      end else begin
        bitCnt  <= bitCnt + BITWIDTH'(1);
        onesCnt <= oTotal;
      end
    end
  end

endmodule

// File: rtl/sc_win_decode.sv
// Windowed stochastic-to-binary decoder: per-window ones count and
// fixed-point probability, delivered over a valid/ready handshake.
module sc_win_decode
  import sc_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iClr,
  input  logic                 iEn,
  input  logic [BITWIDTH-1:0]  iWINLOG2,
  input  logic                 iBit,
  input  logic                 iReady,
  output logic                 oValid,
  output logic [BITWIDTH-1:0]  oOnes,
  output logic [FBITWIDTH-1:0] oProb,
  output logic                 oOvf
);

  logic                 last;
  logic [BITWIDTH-1:0]  total;
  logic [BITWIDTH-1:0]  effL;
  logic [FBITWIDTH-1:0] prob;

  sc_ones_counter #(
    .BITWIDTH(BITWIDTH)
  ) u_cnt (
    .iClk    (iClk),
    .iRst    (iRst),
    .iClr    (iClr),
    .iEn     (iEn),
    .iWINLOG2(iWINLOG2),
    .iBit    (iBit),
    .oLast   (last),
    .oTotal  (total),
    .oEffL   (effL)
  );

  assign prob = FBITWIDTH'(scale(32'(total), 32'(effL), FBITWIDTH));

  // Result register boundary: a completing window always wins over a transfer.
  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      oValid <= 1'b0;
      oOnes  <= '0;
      oProb  <= '0;
      oOvf   <= 1'b0;
    end else if (last) begin
      oOnes  <= total;
      oProb  <= prob;
      oValid <= 1'b1;
      if (oValid && !iReady)
        oOvf <= 1'b1;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_win_decode.sv
// Directed bench for sc_win_decode: expected results are queued as stimulus
// is issued and popped by a monitor on each handshake transfer.
`timescale 1ns/1ps
module tb_sc_win_decode;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iClr = 1'b0;
  logic       iEn = 1'b0;
  logic [7:0] iWINLOG2 = 8'd3;
  logic       iBit = 1'b0;
  logic       iReady = 1'b1;
  logic       oValid;
  logic [7:0] oOnes;
  logic [3:0] oProb;
  logic       oOvf;

  typedef struct {
    int ones;
    int prob;
    int ovf;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  sc_win_decode #(.BITWIDTH(8), .FBITWIDTH(4)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iClr    (iClr),
    .iEn     (iEn),
    .iWINLOG2(iWINLOG2),
    .iBit    (iBit),
    .iReady  (iReady),
    .oValid  (oValid),
    .oOnes   (oOnes),
    .oProb   (oProb),
    .oOvf    (oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ones, input int prob, input int ovf);
    exp_t e;
    e.ones = ones;
    e.prob = prob;
    e.ovf  = ovf;
    expq.push_back(e);
  endtask

  task automatic tick(input logic b);
    iBit = b;
    iEn  = 1'b1;
    @(posedge iClk);
    #1;
    iEn  = 1'b0;
  endtask

  task automatic idle(input int n);
    iEn = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_ones"}, oOnes, 0);
    chk({tag, "_prob"}, oProb, 0);
    chk({tag, "_ovf"}, oOvf, 0);
  endtask

  // Monitor: every transfer must match the oldest queued expectation.
  always @(negedge iClk) begin
    if (oValid && iReady) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got ones=%0d prob=%0d, none expected", oOnes, oProb);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("sb_ones", oOnes, e.ones);
        chk("sb_prob", oProb, e.prob);
        chk("sb_ovf", oOvf, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] alt;
    repeat (3) @(posedge iClk);
    #1;
    chk_zero("reset");
    iRst = 1'b0;

    // All ones, 8-bit windows
    iWINLOG2 = 8'd3;
    idle(1);
    push(8, 8, 0);
    for (int i = 0; i < 7; i++) tick(1'b1);
    chk("t1_latency_early", oValid, 0);
    tick(1'b1);
    chk("t1_latency_valid", oValid, 1);
    chk("t1_ones_direct", oOnes, 8);
    push(8, 8, 0);
    for (int i = 0; i < 8; i++) tick(1'b1);

    // Alternating 1/0, 16-bit windows back to back
    idle(1);
    iWINLOG2 = 8'd4;
    push(8, 4, 0);
    push(8, 4, 0);
    alt = 8'b0101_0101;
    for (int i = 0; i < 32; i++) tick(alt[i % 8]);

    // Overrun with consumer stalled, then clear
    idle(1);
    iWINLOG2 = 8'd2;
    iReady = 1'b0;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    chk("t3_first_valid", oValid, 1);
    chk("t3_first_ones", oOnes, 1);
    chk("t3_first_prob", oProb, 2);
    idle(2);
    chk("t3_hold_ones", oOnes, 1);
    chk("t3_hold_ovf", oOvf, 0);
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
    chk("t3_over_ones", oOnes, 3);
    chk("t3_over_ovf", oOvf, 1);
    push(3, 6, 1);
    iReady = 1'b1;
    idle(1);
    chk("t3_after_xfer_valid", oValid, 0);
    chk("t3_sticky_ovf", oOvf, 1);
    iClr = 1'b1;
    idle(1);
    iClr = 1'b0;
    chk_zero("t3_clr");

    // Exponent change mid-window, then saturated exponent
    iWINLOG2 = 8'd3;
    idle(1);
    push(4, 4, 0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    iWINLOG2 = 8'd2;
    tick(1'b1);
    tick(1'b0);
    chk("t4_no_early_end", oValid, 0);
    tick(1'b0); tick(1'b1);
    push(3, 6, 0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    idle(1);
    iWINLOG2 = 8'd200;
    push(128, 8, 0);
    for (int i = 0; i < 127; i++) tick(1'b1);
    chk("t4_sat_not_done", oValid, 0);
    tick(1'b1);
    chk("t4_sat_done", oValid, 1);

    // Enable paused mid-window
    idle(1);
    iWINLOG2 = 8'd3;
    push(3, 3, 0);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    iBit = 1'b1;
    idle(5);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);

    // Single-bit windows: oValid stays high, one result per cycle
    idle(1);
    iWINLOG2 = 8'd0;
    push(1, 8, 0);
    push(0, 0, 0);
    push(1, 8, 0);
    tick(1'b1); tick(1'b0); tick(1'b1);

    // Clear coincident with a window completion discards it
    idle(1);
    iWINLOG2 = 8'd1;
    tick(1'b1);
    iClr = 1'b1;
    tick(1'b1);
    iClr = 1'b0;
    chk("t7_clr_wins", oValid, 0);
    push(1, 4, 0);
    tick(1'b0); tick(1'b1);

    // Reset held mid-window with bits still arriving
    idle(1);
    iWINLOG2 = 8'd2;
    tick(1'b1); tick(1'b1);
    iRst = 1'b1;
    iEn = 1'b1;
    iBit = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iEn = 1'b0;
    chk_zero("t8_rst");
    iRst = 1'b0;
    push(1, 2, 0);
    tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);

    idle(3);
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_win_decode.md
# sc_win_decode

Windowed stochastic-to-binary decoder that sits directly downstream of the bit-flip insertion stage in the stochastic-computing datapath. It counts ones in the incoming bitstream over consecutive windows of 2^WINLOG2 bits and emits, per window, the raw ones count and the fixed-point probability in the same format the insertion stage takes as its target. Results are delivered over a valid/ready handshake, so the stage can check the achieved probability against the target or feed a binary consumer.

## Interface
- BITWIDTH, 8: width of the window and counter logic; maximum window is 2^(BITWIDTH-1) bits.
- FBITWIDTH, 4: probability width, with FBITWIDTH-1 fractional bits (1.0 = 2^(FBITWIDTH-1), 0.5 = 2^(FBITWIDTH-2)); must be ≥ 2.

- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iClr  in  1  synchronous clear, lower priority than iRst.
- iEn  in  1  bit-sample enable; low = pause.
- iWINLOG2  in  BITWIDTH  log2 of window length.
- iBit  in  1  stochastic bitstream input (insertion-stage output).
- iReady  in  1  consumer accepts result.
- oValid  out  1  result available.
- oOnes  out  BITWIDTH  ones counted in the completed window.
- oProb  out  FBITWIDTH  estimated probability of the completed window.
- oOvf  out  1  sticky: a result was overwritten before acceptance.

## Operation
- Internal state: bitCnt (BITWIDTH), onesCnt (BITWIDTH), winLog (latched window exponent), result register (oOnes, oProb), oValid, oOvf.
- iRst or iClr: bitCnt, onesCnt, oOnes, oProb, oValid and oOvf go to 0; winLog loads sat(iWINLOG2). sat(x) = min(x, BITWIDTH-1).
- Window start: when iEn and bitCnt == 0, winLog loads sat(iWINLOG2). Mid-window changes of iWINLOG2 are ignored until the next window.
- Effective exponent for the current cycle, L: sat(iWINLOG2) when bitCnt == 0, otherwise winLog.
- Each cycle with iEn = 1:
  - Sample iBit.
  - If bitCnt ≠ 2^L − 1: bitCnt++ and onesCnt += iBit.
  - Else (last bit): total = onesCnt + iBit. Load oOnes = total and oProb = scale(total, L). Set oValid. Clear bitCnt and onesCnt so the next window starts back-to-back.
- iEn = 0: counters and winLog hold. The handshake still operates.
- scale(total, L): if L ≥ FBITWIDTH−1, total >> (L−(FBITWIDTH−1)), truncating; else total << (FBITWIDTH−1−L). An all-ones window yields exactly 2^(FBITWIDTH-1).
- L = 0: every enabled cycle completes a window. oProb is 0 or 1.0.
- Handshake: a transfer occurs when oValid & iReady. After a transfer, oValid clears unless a new window completes in the same cycle, in which case the new result loads and oValid stays 1.
- Overrun: a window completes while oValid = 1 and iReady = 0. The new result overwrites and oOvf sets. oOvf clears only on iRst or iClr.
- oOnes and oProb are stable while oValid = 1 and iReady = 0, except on overrun.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: the last window bit is sampled at edge k; oValid, oOnes and oProb are updated after edge k.
- Throughput: one window per 2^L enabled cycles, with no idle cycle between windows.
- iClr asserted in the same cycle as a window completion: the clear wins and the result is discarded.
- iRst or iClr mid-window: the partial window is discarded, and counting restarts with the next enabled cycle as bit 0.
- iReady is ignored while oValid = 0.

## Structure
- Shared package sc_pkg: the FBITWIDTH fixed-point constants (ONE, HALF) and the sat/scale helper functions, shared with the insertion stage.
- One natural sub-module: sc_ones_counter (bitCnt, onesCnt and winLog latching, last-bit detection). The top level holds the scaling, result register and handshake.

## Test plan
- All-ones stream, iWINLOG2 = 3, iReady = 1 → oValid pulses every 8 cycles with oOnes = 8 and oProb = 4'b1000.
- Alternating 1/0, iWINLOG2 = 4 → oOnes = 8 and oProb = 4'b0100 each window; no gap between windows.
- iReady = 0 across two window completions → first result held, then overwritten by the second, oOvf = 1. iClr → all outputs 0.
- iWINLOG2 changed from 3 to 2 at mid-window bit 4 → current window still 8 bits; next window 4 bits. iWINLOG2 = 200 → treated as 7.
- iEn toggled low for 5 cycles mid-window → count unaffected (e.g. 3 ones in an 8-bit window gives oOnes = 3, oProb = 4'b0011).
- iRst held mid-window, then released → all outputs 0; the first result reflects only bits after release.
